// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 display chain controller: frame width,
// FSM states and the frame-word bit order used by both RTL and bench.
package hc595_pkg;

    localparam int FRAME_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_e;

    // Bit 0 leaves first, so sel[0] lands furthest down the chain.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [5:0] sel,
                                                      input logic [7:0] seg);
        logic [FRAME_W-1:0] w;
        w[5:0] = sel;
        for (int i = 0; i < 8; i++) begin
            w[13-i] = seg[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/hc595_ctrl.sv
// Serialises the 6-bit digit select and 8-bit segment pattern into a two-chip
// 74HC595 chain, latches each frame, and keeps the display dark until then.
//
// state | meaning
// IDLE  | waiting for a start condition; ds holds the last bit shifted
// SHIFT | clocking 14 bits out, shcp half-period = CLK_DIV cycles
// LATCH | stcp held high for CLK_DIV cycles, then outputs enabled
module hc595_ctrl
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CONT    = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] sel,
    input  logic [7:0] seg,
    output logic       ds,
    output logic       shcp,
    output logic       stcp,
    output logic       oe
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_W - 1);

    state_e             state_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [3:0]         bit_cnt_q;
    logic               phase_q;
    logic               valid_q;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] last_q;
    logic               ds_q;
    logic               shcp_q;
    logic               stcp_q;
    logic               oe_q;

    logic [FRAME_W-1:0] frame_d;
    logic               start_d;
    logic               div_tc;

    assign frame_d = pack_frame(sel, seg);
    assign start_d = (CONT != 0) || !valid_q || (frame_d != last_q);
    assign div_tc  = (div_cnt_q == DIV_TC);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            phase_q   <= 1'b0;
            valid_q   <= 1'b0;
            frame_q   <= '0;
            last_q    <= '0;
            ds_q      <= 1'b0;
            shcp_q    <= 1'b0;
            stcp_q    <= 1'b0;
            oe_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        frame_q   <= frame_d;
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        phase_q   <= 1'b0;
                        ds_q      <= frame_d[0];
                        shcp_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        phase_q   <= !phase_q;
                        if (!phase_q) begin
                            shcp_q <= 1'b1;
                        end else begin
                            shcp_q <= 1'b0;
                            if (bit_cnt_q < LAST_BIT) begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                                ds_q      <= frame_q[bit_cnt_q + 4'd1];
                            end else begin
                                stcp_q  <= 1'b1;
                                state_q <= LATCH;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_tc) begin
                        div_cnt_q <= '0;
                        stcp_q    <= 1'b0;
                        last_q    <= frame_q;
                        valid_q   <= 1'b1;
                        oe_q      <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ds   = ds_q;
    assign shcp = shcp_q;
    assign stcp = stcp_q;
    assign oe   = oe_q;

endmodule

// File: tb/tb_hc595_ctrl.sv
// Bench for hc595_ctrl: three instances (CLK_DIV=2/CONT=1, CLK_DIV=2/CONT=0,
// CLK_DIV=1/CONT=1), each watched by a 74HC595 chain model and scoreboard.
module tb_hc595_ctrl;
    import hc595_pkg::*;

    typedef struct {
        logic [13:0] word;
        int          e0;
    } exp_t;

    logic       clk;
    int         cyc;
    logic       rst_n  [3];
    logic       mon_en [3];
    logic [5:0] sel_r  [3];
    logic [7:0] seg_r  [3];
    logic       ds_w   [3];
    logic       shcp_w [3];
    logic       stcp_w [3];
    logic       oe_w   [3];
    int         act_cnt[3];
    exp_t       exp_q  [3][$];

    int n_checks = 0;
    int n_fail   = 0;

    hc595_ctrl #(.CLK_DIV(2), .CONT(1)) u_cont (
        .sys_clk(clk), .sys_rst_n(rst_n[0]), .sel(sel_r[0]), .seg(seg_r[0]),
        .ds(ds_w[0]), .shcp(shcp_w[0]), .stcp(stcp_w[0]), .oe(oe_w[0]));

    hc595_ctrl #(.CLK_DIV(2), .CONT(0)) u_evt (
        .sys_clk(clk), .sys_rst_n(rst_n[1]), .sel(sel_r[1]), .seg(seg_r[1]),
        .ds(ds_w[1]), .shcp(shcp_w[1]), .stcp(stcp_w[1]), .oe(oe_w[1]));

    hc595_ctrl #(.CLK_DIV(1), .CONT(1)) u_div1 (
        .sys_clk(clk), .sys_rst_n(rst_n[2]), .sel(sel_r[2]), .seg(seg_r[2]),
        .ds(ds_w[2]), .shcp(shcp_w[2]), .stcp(stcp_w[2]), .oe(oe_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int i, input logic [13:0] w, input int e0);
        exp_t e;
        e.word = w;
        e.e0   = e0;
        exp_q[i].push_back(e);
    endtask

    // Returns at the first falling edge where the cycle count has reached t.
    task automatic wait_neg(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // 595 chain model and protocol monitor, one per instance.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int DV = (g == 2) ? 1 : 2;
        logic [13:0] sr, latched;
        int          rises, ds_same, first_rise, stcp_rise;
        logic        prev_shcp, prev_stcp, prev_ds, ds_rise, proto_err, seen_latch;

        initial act_cnt[g] = 0;

        always @(negedge clk) begin
            exp_t e;
            if (!rst_n[g]) begin
                sr = '0; rises = 0; ds_same = 0; proto_err = 1'b0; seen_latch = 1'b0;
            end else if (mon_en[g]) begin
                ds_same = (ds_w[g] == prev_ds) ? ds_same + 1 : 1;
                if (shcp_w[g] && stcp_w[g]) proto_err = 1'b1;
                if (shcp_w[g] && !prev_shcp) begin
                    if (rises == 0) begin
                        first_rise = cyc;
                        check($sformatf("frame_expected[%0d]", g), 32'(exp_q[g].size() > 0), 1);
                    end
                    if (ds_same < DV + 1) proto_err = 1'b1;
                    ds_rise = ds_w[g];
                    sr      = {ds_w[g], sr[13:1]};
                    rises++;
                    act_cnt[g]++;
                end else if (shcp_w[g] && ds_w[g] != ds_rise) begin
                    proto_err = 1'b1;
                end
                if (stcp_w[g] && !prev_stcp) begin
                    stcp_rise = cyc;
                    latched   = sr;
                    act_cnt[g]++;
                    if (!seen_latch) check($sformatf("oe_dark[%0d]", g), 32'(oe_w[g]), 1);
                end
                if (!stcp_w[g] && prev_stcp) begin
                    if (exp_q[g].size() == 0) begin
                        check($sformatf("exp_avail[%0d]", g), 0, 1);
                    end else begin
                        e = exp_q[g].pop_front();
                        check($sformatf("word[%0d]", g), 32'(latched), 32'(e.word));
                        check($sformatf("rises[%0d]", g), rises, 14);
                        check($sformatf("protocol[%0d]", g), 32'(proto_err), 0);
                        check($sformatf("first_rise[%0d]", g), first_rise, e.e0 + DV);
                        check($sformatf("stcp_rise[%0d]", g), stcp_rise, e.e0 + 28 * DV);
                        check($sformatf("stcp_fall[%0d]", g), cyc, e.e0 + 29 * DV);
                        check($sformatf("oe_on[%0d]", g), 32'(oe_w[g]), 0);
                    end
                    seen_latch = 1'b1;
                    rises      = 0;
                    proto_err  = 1'b0;
                end
            end
            prev_shcp = shcp_w[g];
            prev_stcp = stcp_w[g];
            prev_ds   = ds_w[g];
        end
    end

    task automatic run0();
        int e0, r;
        wait_neg(4);
        rst_n[0] = 1'b1;
        e0 = 5;
        push(0, 14'h00FE, e0);
        push(0, 14'h00FE, e0 + 59);
        push(0, 14'h00FE, e0 + 118);
        e0 = e0 + 118;
        // abort the third frame just after its 7th shift-clock rise
        wait_neg(e0 + 26);
        #1 rst_n[0] = 1'b0;
        #1;
        check("rst_ds", 32'(ds_w[0]), 0);
        check("rst_shcp", 32'(shcp_w[0]), 0);
        check("rst_stcp", 32'(stcp_w[0]), 0);
        check("rst_oe", 32'(oe_w[0]), 1);
        void'(exp_q[0].pop_back());
        r = e0 + 30;
        wait_neg(r);
        rst_n[0] = 1'b1;
        e0 = r + 1;
        push(0, 14'h00FE, e0);
        for (int i = 0; i < 5; i++) begin
            e0 = e0 + 59;
            wait_neg(e0 - 1);
            if (i < 4) begin
                sel_r[0] = 6'($urandom);
                seg_r[0] = 8'($urandom);
            end
            push(0, pack_frame(sel_r[0], seg_r[0]), e0);
        end
        wait_neg(e0 + 10);
        check("leftover[0]", exp_q[0].size(), 1);
        mon_en[0] = 1'b0;
    endtask

    task automatic run1();
        int e0, a;
        wait_neg(4);
        rst_n[1] = 1'b1;
        e0 = 5;
        push(1, 14'h00FE, e0);
        wait_neg(e0 + 60);
        a = act_cnt[1];
        wait_neg(e0 + 560);
        check("idle_quiet", act_cnt[1], a);
        seg_r[1] = 8'hF9;
        e0 = e0 + 561;
        push(1, 14'h27FE, e0);
        wait_neg(e0 + 60);
        seg_r[1] = 8'hC0;
        e0 = e0 + 61;
        push(1, 14'h00FE, e0);
        wait_neg(e0 + 18);
        seg_r[1] = 8'h00;
        e0 = e0 + 59;
        push(1, 14'h003E, e0);
        wait_neg(e0 + 60);
        check("leftover[1]", exp_q[1].size(), 0);
        a = act_cnt[1];
        wait_neg(e0 + 120);
        check("quiet_after", act_cnt[1], a);
        mon_en[1] = 1'b0;
    endtask

    task automatic run2();
        int e0;
        wait_neg(4);
        rst_n[2] = 1'b1;
        e0 = 5;
        push(2, 14'h00FE, e0);
        for (int i = 0; i < 7; i++) begin
            e0 = e0 + 30;
            wait_neg(e0 - 1);
            if (i < 6) begin
                sel_r[2] = 6'($urandom);
                seg_r[2] = 8'($urandom);
            end
            push(2, pack_frame(sel_r[2], seg_r[2]), e0);
        end
        wait_neg(e0 + 5);
        check("leftover[2]", exp_q[2].size(), 1);
        mon_en[2] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]  = 1'b0;
            mon_en[i] = 1'b1;
            sel_r[i]  = 6'b111110;
            seg_r[i]  = 8'hC0;
        end
        wait_neg(2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_ds[%0d]", i), 32'(ds_w[i]), 0);
            check($sformatf("reset_shcp[%0d]", i), 32'(shcp_w[i]), 0);
            check($sformatf("reset_stcp[%0d]", i), 32'(stcp_w[i]), 0);
            check($sformatf("reset_oe[%0d]", i), 32'(oe_w[i]), 1);
        end
        check("pack_c0", 32'(pack_frame(6'b111110, 8'hC0)), 32'h00FE);
        fork
            run0();
            run1();
            run2();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hc595_ctrl.md
# hc595_ctrl

Serial controller that drives a two-chip 74HC595 chain carrying the 6-bit digit-select and 8-bit segment pattern of the static seven-segment display. It sits between the segment-pattern generator (parallel `sel`/`seg`) and the board pins `ds`/`shcp`/`stcp`/`oe`. Each frame snapshots the inputs, shifts 14 bits out with a programmable shift-clock rate, then pulses the storage clock. It holds the display dark until the first complete frame is latched.

## Interface
- `CLK_DIV`, default 2: `sys_clk` cycles per `shcp` half-period; legal values are 1 and above.
- `CONT`, default 1: 1 = refresh continuously; 0 = start a frame only on an input change, or on the first frame after reset.
- `sys_clk`  in  1  system clock; all logic uses the rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `sel`  in  6  digit-select pattern, sampled at frame start.
- `seg`  in  8  segment pattern (bit 7 = dp), sampled at frame start.
- `ds`  out  1  serial data to the first 595 `DS` pin; registered.
- `shcp`  out  1  shift clock; registered.
- `stcp`  out  1  storage (latch) clock; registered.
- `oe`  out  1  active-low output enable; registered.

## Operation
- Frame word, 14 bits: `{seg[0],seg[1],…,seg[7],sel[5:0]}`. It is shifted LSB first, so `ds` order is sel[0]…sel[5], seg[7]…seg[0].
- States:
  - IDLE: if the start condition holds, load the frame word, set bit_cnt=0, div_cnt=0, phase=0, drive `ds`=bit 0 and `shcp`=0, and go to SHIFT.
    - Start condition when CONT=1: always true.
    - Start condition when CONT=0: `!valid || {seg,sel} != last`.
  - SHIFT: div_cnt counts 0..CLK_DIV-1; at terminal count the phase flips.
    - Phase 0 → 1: `shcp`←1.
    - Phase 1 → 0 with bit_cnt<13: `shcp`←0, bit_cnt++, `ds`←next bit.
    - Phase 1 → 0 with bit_cnt==13: `shcp`←0, `stcp`←1, go to LATCH.
  - LATCH: hold `stcp`=1 for CLK_DIV cycles. Then `stcp`←0, `last`←frame, `valid`←1, `oe`←0, and go to IDLE.
- `oe` never returns high except through reset.
- `ds` holds its final bit value in IDLE.
- Input changes during SHIFT or LATCH are ignored; the snapshot is used. A change is picked up on the next IDLE evaluation (CONT=0).
- Reset at any point asynchronously forces:
  - outputs: `ds`=0, `shcp`=0, `stcp`=0, `oe`=1;
  - internal: state=IDLE, `valid`=0, `last`=0, all counters 0.
  - The partial frame is discarded; the display stays dark until the next full frame latches.
- Width rules: div_cnt is `$clog2(CLK_DIV+1)` bits; bit_cnt is 4 bits, max 13.

## Timing
- Reference point: edge E0 is the IDLE edge that samples the inputs.
- `ds` is valid after E0.
- `shcp` rises at E0+(2k+1)·CLK_DIV and falls at E0+(2k+2)·CLK_DIV, for k=0..13.
- `ds` setup to each `shcp` rise = CLK_DIV cycles; hold after the rise = CLK_DIV cycles. `ds` changes on the same edge as the `shcp` fall.
- `stcp` is high from E0+28·CLK_DIV to E0+29·CLK_DIV.
- `oe` falls at E0+29·CLK_DIV on the first frame.
- The state returns to IDLE at E0+29·CLK_DIV. The next sample edge is E0+29·CLK_DIV+1.
- Frame period with CONT=1: 29·CLK_DIV+1 cycles.
- Exactly 14 `shcp` rising edges and 1 `stcp` pulse per frame.
- `shcp` and `stcp` are never high simultaneously.

## Structure
- Shared package `hc595_pkg`:
  - `FRAME_W`=14;
  - state enum {IDLE, SHIFT, LATCH};
  - frame-word packing function `pack_frame(sel,seg)`, so the bench reuses the bit order.
- No sub-module: the divider, FSM and shift register are small and tightly coupled, so they live in one module.

## Test plan
- First frame, CLK_DIV=2, CONT=1, seg=8'hC0, sel=6'b111110, release reset:
  - `ds` at the 14 `shcp` rises = 0,1,1,1,1,1,1,1,0,0,0,0,0,0;
  - `stcp` high for cycles 56–57 after E0;
  - `oe` falls at cycle 58;
  - next frame samples at cycle 59.
- CONT=0 with steady inputs:
  - after the first frame, no further `shcp`/`stcp` activity for 500 cycles;
  - change seg to 8'hF9: a new frame starts on the next cycle, and the latched word equals `pack_frame(sel,8'hF9)`.
- Input change mid-frame: change seg from 8'hC0 to 8'h00 at the 5th `shcp` rise → the shifted word is still the 8'hC0 word. With CONT=0, a second frame with 8'h00 follows immediately.
- Reset mid-frame: assert `sys_rst_n`=0 after the 7th `shcp` rise →
  - same cycle (asynchronous): `ds`=0, `shcp`=0, `stcp`=0, `oe`=1;
  - after release: a full 14-bit frame is sent, and `oe` stays 1 until its `stcp` pulse completes.
- CLK_DIV=1 → `shcp` toggles every cycle, 14 rises, `stcp` high exactly 1 cycle, period 30 cycles.
- Protocol check over 10 random frames:
  - `stcp` never overlaps `shcp`=1;
  - `ds` is stable for CLK_DIV cycles around each `shcp` rise;
  - the scoreboarded 595 model output equals `pack_frame` of the sampled inputs.
